// File: rtl/apb_regfile_completer_pkg.sv
// Shared APB definitions: completer FSM states, ID register defaults and the
// address classifier used by both the completer and the master-side checker.
package apb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   typedef enum logic [1:0] {
      ADDR_MEM = 2'd0,
      ADDR_ID  = 2'd1,
      ADDR_ERR = 2'd2
   } addr_class_e;

   localparam logic [7:0] ID_ADDR_DEFAULT  = 8'hFF;
   localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

   // The ID address wins over the RW window so a misplaced ID never aliases a register.
   function automatic addr_class_e decode_addr(input logic [31:0] addr,
                                               input logic [31:0] depth,
                                               input logic [31:0] id_addr);
      addr_class_e cls;
      if (addr == id_addr) begin
         cls = ADDR_ID;
      end else if (addr < depth) begin
         cls = ADDR_MEM;
      end else begin
         cls = ADDR_ERR;
      end
      return cls;
   endfunction

endpackage

// File: rtl/apb_regfile_completer_if.sv
// APB bus bundle between the team's master and a completer.
interface apb_regfile_completer_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              P_sel;
   logic              P_enable;
   logic              P_write;
   logic [ADDR_W-1:0] P_addr;
   logic [DATA_W-1:0] P_wdata;
   logic [DATA_W-1:0] P_rdata;
   logic              P_ready;
   logic              P_slverr;

   modport master (
      output P_sel, P_enable, P_write, P_addr, P_wdata,
      input  P_rdata, P_ready, P_slverr
   );

   modport slave (
      input  P_sel, P_enable, P_write, P_addr, P_wdata,
      output P_rdata, P_ready, P_slverr
   );
endinterface

// File: rtl/apb_regfile_completer_wait_counter.sv
// Access-phase wait-state counter: loaded at setup, counts down while the
// master holds the access phase, flags zero on the completion cycle.
module apb_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);
   logic [3:0] count_r;

   // Down-counter, reloaded on every setup phase
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= 4'd0;
      end else if (load) begin
         count_r <= 4'(WAIT_CYCLES);
      end else if (dec && (count_r != 4'd0)) begin
         count_r <= count_r - 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == 4'd0);
endmodule

// File: rtl/apb_regfile_completer.sv
// APB completer: DEPTH-entry RW register file, read-only ID register,
// programmable wait states, PSLVERR on illegal accesses and debug counters.
module apb_regfile_completer
   import apb_pkg::*;
#(
   parameter int unsigned       DATA_W      = 8,
   parameter int unsigned       ADDR_W      = 8,
   parameter int unsigned       DEPTH       = 64,
   parameter int unsigned       WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] ID_ADDR     = ADDR_W'(ID_ADDR_DEFAULT),
   parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(ID_VALUE_DEFAULT)
) (
   input  logic                    P_clk,
   input  logic                    P_reset,
   apb_regfile_completer_if.slave  bus,
   output logic [15:0]             txn_count,
   output logic [7:0]              err_count
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

   apb_state_e        state_r;
   apb_state_e        state_nxt_s;
   logic              setup_s;
   logic              dec_s;
   logic              ready_s;
   logic              zero_s;
   addr_class_e       setup_cls_s;
   logic              setup_err_s;
   logic [DATA_W-1:0] setup_rdata_s;
   logic [IDX_W-1:0]  idx_r;
   logic              write_r;
   logic              err_r;
   logic [DATA_W-1:0] rdata_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [15:0]       txn_r;
   logic [7:0]        errc_r;

   apb_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk  (P_clk),
      .rst  (P_reset),
      .load (setup_s),
      .dec  (dec_s),
      .zero (zero_s)
   );

   // FSM state register
   always_ff @(posedge P_clk) begin
      if (P_reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state; dropping P_sel in ACCESS is a master abort
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.P_sel && !bus.P_enable) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!bus.P_sel) begin
               state_nxt_s = ST_IDLE;
            end else if (bus.P_enable && zero_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      setup_s = 1'b0;
      dec_s   = 1'b0;
      ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            setup_s = bus.P_sel && !bus.P_enable;
         end
         ST_ACCESS: begin
            dec_s   = bus.P_sel && bus.P_enable && !zero_s;
            ready_s = bus.P_sel && bus.P_enable && zero_s;
         end
         default: begin
            setup_s = 1'b0;
         end
      endcase
   end

   // Setup-phase address decode: error flag and read data to latch
   always_comb begin
      setup_cls_s   = decode_addr(32'(bus.P_addr), 32'(DEPTH), 32'(ID_ADDR));
      setup_err_s   = 1'b0;
      setup_rdata_s = ZERO_DATA;
      case (setup_cls_s)
         ADDR_MEM: begin
            setup_rdata_s = mem_r[bus.P_addr[IDX_W-1:0]];
         end
         ADDR_ID: begin
            setup_err_s   = bus.P_write;
            setup_rdata_s = bus.P_write ? ZERO_DATA : ID_VALUE;
         end
         default: begin
            setup_err_s   = 1'b1;
            setup_rdata_s = ZERO_DATA;
         end
      endcase
   end

   // Transfer latches, register file and counters
   always_ff @(posedge P_clk) begin
      if (P_reset) begin
         idx_r   <= {IDX_W{1'b0}};
         write_r <= 1'b0;
         err_r   <= 1'b0;
         rdata_r <= ZERO_DATA;
         mem_r   <= '{default: ZERO_DATA};
         txn_r   <= 16'd0;
         errc_r  <= 8'd0;
      end else begin
         if (setup_s) begin
            idx_r   <= bus.P_addr[IDX_W-1:0];
            write_r <= bus.P_write;
            err_r   <= setup_err_s;
            rdata_r <= setup_rdata_s;
         end
         if (ready_s) begin
            if (write_r && !err_r) begin
               mem_r[idx_r] <= bus.P_wdata;
            end
            txn_r <= txn_r + 16'd1;
            if (err_r && (errc_r != 8'hFF)) begin
               errc_r <= errc_r + 8'd1;
            end
         end
      end
   end

   assign bus.P_rdata  = rdata_r;
   assign bus.P_ready  = ready_s;
   assign bus.P_slverr = ready_s && err_r;
   assign txn_count    = txn_r;
   assign err_count    = errc_r;
endmodule

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

APB completer (responder) that answers transfers issued by the team's APB master: a DEPTH-entry byte register file with a fixed number of programmable wait states, a read-only ID register and PSLVERR signalling for illegal accesses. It sits on the slave side of the P_* bus and exports transfer and error counters for debug. It replaces the bare slave wherever wait-state and error-path coverage of the master is needed.

## Interface
- DATA_W, 8, data width of P_wdata/P_rdata
- ADDR_W, 8, address width of P_addr
- DEPTH, 64, number of RW registers at addresses 0..DEPTH-1; must be ≤ 2^ADDR_W - 1
- WAIT_CYCLES, 2, access-phase cycles with P_ready low before completion (0..15)
- ID_ADDR, 8'hFF, address of read-only ID register
- ID_VALUE, 8'hA5, value returned at ID_ADDR
---
- P_clk  in  1  clock; everything on rising edge
- P_reset  in  1  synchronous, active-high reset
- P_sel  in  1  completer select
- P_enable  in  1  access-phase marker
- P_write  in  1  1 = write, 0 = read
- P_addr  in  ADDR_W  transfer address
- P_wdata  in  DATA_W  write data
- P_rdata  out  DATA_W  read data, valid while P_ready=1 on a read
- P_ready  out  1  transfer completion
- P_slverr  out  1  error response, valid only while P_ready=1
- txn_count  out  16  completed transfers, wraps FFFF→0000
- err_count  out  8  completed transfers with P_slverr=1, saturates at FF

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: on P_sel=1 & P_enable=0 (setup phase) → latch P_addr, P_write, compute err_flag, load wait counter with WAIT_CYCLES, latch P_rdata; go to ACCESS. Anything else: stay.
- err_flag = (addr ≥ DEPTH and addr ≠ ID_ADDR) or (write and addr = ID_ADDR).
- Read data latched at setup: mem[addr] if addr < DEPTH; ID_VALUE if addr = ID_ADDR; 0 on any error. P_rdata holds its last value outside transfers.
- ACCESS with P_sel=1 & P_enable=1: if counter ≠ 0, decrement, P_ready=0. If counter = 0, P_ready=1 (completion cycle).
- Completion edge: if write and !err_flag, mem[latched addr] ← P_wdata sampled on that edge; txn_count+1; err_count+1 if err_flag (saturating); → IDLE.
- Error writes never modify state; error reads return 0.
- ACCESS with P_sel=0 (master abort): → IDLE, no write, no count update.
- P_addr/P_write changes during ACCESS are ignored (latched values used).
- Back-to-back: setup of the next transfer may follow the completion cycle immediately; IDLE accepts it that cycle.

## Timing
- Reset (P_reset=1 at an edge): state IDLE, all mem entries 0, P_rdata=0, P_ready=0, P_slverr=0, txn_count=0, err_count=0. Reset mid-transfer aborts it with no write.
- P_ready = (state = ACCESS) & (counter = 0) & P_sel & P_enable; P_slverr = P_ready & err_flag. Both are decoded from registered state; no combinational path from P_wdata.
- Access phase lasts WAIT_CYCLES+1 cycles; total transfer = WAIT_CYCLES+2 cycles including setup. WAIT_CYCLES=0 gives the standard two-cycle APB transfer.
- Written value is visible to a read whose setup cycle follows the completion cycle.

## Structure
- Shared package apb_pkg: FSM state enum, ID_ADDR/ID_VALUE defaults, and the address-decode function (in-range / ID / error) shared with the master-side checker.
- One natural sub-module: apb_wait_counter (load, decrement, zero flag). Register file stays inline.

## Test plan
- Reset then read addr 0x10 (WAIT=2) → P_ready high on 3rd access-phase cycle, P_rdata=00, P_slverr=0, txn_count=1.
- Write 0x3C to 0x05, then read 0x05 back-to-back → read returns 3C; txn_count=2; each transfer 4 cycles.
- Read ID_ADDR 0xFF → P_rdata=A5, P_slverr=0; write 0x11 to 0xFF → P_slverr=1, subsequent read still A5, err_count=1.
- Read 0x40 (=DEPTH) → P_slverr=1, P_rdata=00; write 0x77 to 0x80 → P_slverr=1, no register changes.
- Drop P_sel during wait states of a write to 0x02 → no P_ready, mem[0x02] unchanged, counters unchanged; next transfer completes normally.
- Assert P_reset during a write's access phase after 0x12 was written to 0x01 → mem[0x01]=00, counters 0, P_ready=0; WAIT_CYCLES=0 build: all transfers complete in 2 cycles.
